// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD window trigger.
package sad_pkg;

  // Trigger core states
  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StHold,
    StDone
  } sad_state_e;

  // Edges from the sample on adc_datain to the compare register
  localparam int unsigned SAD_LATENCY = 3;

  // Width of one window sum: N samples of B bits can never overflow this
  function automatic int unsigned sad_width(input int unsigned n, input int unsigned b);
    return $clog2(n) + b;
  endfunction

endpackage

// File: rtl/sad_accum_lane.sv
// One accumulator lane: absolute-difference stage, running sum, phase and completion flag.
// Lane k pairs sample t with reference index (t - k) mod N, so the N lanes together
// produce one completed window per sample.
module sad_accum_lane
  import sad_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned B    = 12,
  parameter int unsigned LANE = 0,
  localparam int unsigned PW  = $clog2(N),
  localparam int unsigned SW  = sad_width(N, B)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          sample_vld,
  input  logic [B-1:0]  sample,
  input  logic [B-1:0]  ref_sample,
  input  logic          ref_enable,
  output logic [PW-1:0] phase,
  output logic [SW-1:0] sum,
  output logic          done
);

  localparam logic [PW-1:0] PhaseInit = PW'((N - LANE) % N);

  logic [PW-1:0] phase_q, phase1_q;
  logic [B-1:0]  diff_d, diff_q;
  logic          vld1_q;
  logic [SW-1:0] acc_base, acc_q;
  logic          done_q;

  // Masked absolute difference against the reference entry this lane currently points at
  always_comb begin
    diff_d = '0;
    if (ref_enable) begin
      diff_d = (sample > ref_sample) ? (sample - ref_sample) : (ref_sample - sample);
    end
  end

  // Stage 1: register the difference together with the phase it belongs to
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      phase_q  <= PhaseInit;
      phase1_q <= '0;
      diff_q   <= '0;
      vld1_q   <= 1'b0;
    end else begin
      vld1_q <= sample_vld;
      if (sample_vld) begin
        diff_q   <= diff_d;
        phase1_q <= phase_q;
        phase_q  <= phase_q + 1'b1;
      end
    end
  end

  // Phase 0 starts a fresh window; the previous total is dropped
  always_comb begin
    acc_base = (phase1_q == '0) ? '0 : acc_q;
  end

  // Stage 2: accumulate and flag the sample that closes the window
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= vld1_q && (phase1_q == PW'(N - 1));
      if (vld1_q) begin
        acc_q <= acc_base + SW'(diff_q);
      end
    end
  end

  assign phase = phase_q;
  assign sum   = acc_q;
  assign done  = done_q;

endmodule

// File: rtl/sad_window_trigger.sv
// Sliding-window SAD trigger with holdoff, single/multiple mode, sticky flag and
// saturating trigger count. Optional macro SAD_MIN_TRACK_EN adds the sad_min output.
module sad_window_trigger
  import sad_pkg::*;
#(
  parameter int unsigned pREF_SAMPLES     = 32,
  parameter int unsigned pBITS_PER_SAMPLE = 12,
  parameter int unsigned pHOLDOFF_WIDTH   = 16,
  parameter int unsigned pCOUNT_WIDTH     = 8
) (
  input  logic                              clk_adc,
  input  logic                              reset,
  input  logic [pBITS_PER_SAMPLE-1:0]       adc_datain,
  input  logic                              armed_and_ready,
  input  logic                              ref_wr,
  input  logic [$clog2(pREF_SAMPLES)-1:0]   ref_addr,
  input  logic [pBITS_PER_SAMPLE-1:0]       ref_data,
  input  logic                              ref_en,
  input  logic [31:0]                       threshold,
  input  logic                              multiple_triggers,
  input  logic [pHOLDOFF_WIDTH-1:0]         holdoff,
  output logic                              trigger,
  output logic                              triggered,
  output logic [pCOUNT_WIDTH-1:0]           num_triggers
`ifdef SAD_MIN_TRACK_EN
  ,
  output logic [sad_width(pREF_SAMPLES, pBITS_PER_SAMPLE)-1:0] sad_min
`endif
);

  localparam int unsigned N  = pREF_SAMPLES;
  localparam int unsigned B  = pBITS_PER_SAMPLE;
  localparam int unsigned PW = $clog2(N);
  localparam int unsigned SW = sad_width(N, B);

  logic [B-1:0]  ref_mem [N];
  logic [N-1:0]  ref_en_mem;

  logic [B-1:0]  sample_q;
  logic          sample_vld_q;
  logic          lane_clear;
  logic [PW-1:0] lane_phase [N];
  logic [SW-1:0] lane_sum [N];
  logic [N-1:0]  lane_done;
  logic [SW-1:0] done_sum;
  logic          result_ok, hit, window_full;
  logic [SAD_LATENCY-1:0] full_q;

  sad_state_e                state_q, state_d;
  logic [PW-1:0]             fill_cnt_q, fill_cnt_d;
  logic [pHOLDOFF_WIDTH-1:0] hold_cnt_q, hold_cnt_d;
  logic                      trigger_q;
  logic                      triggered_q, triggered_d;
  logic [pCOUNT_WIDTH-1:0]   count_q, count_d;

  // Reference store: only writable while disarmed, deliberately not reset
  always_ff @(posedge clk_adc) begin
    if (ref_wr && !armed_and_ready) begin
      ref_mem[ref_addr]    <= ref_data;
      ref_en_mem[ref_addr] <= ref_en;
    end
  end

  // Stage 0: capture the ADC sample; only samples taken while armed are valid
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      sample_q     <= '0;
      sample_vld_q <= 1'b0;
    end else begin
      sample_q     <= adc_datain;
      sample_vld_q <= armed_and_ready;
    end
  end

  // Lanes restart while disarmed and on the arming edge
  assign lane_clear = !armed_and_ready || (state_q == StIdle);

  for (genvar k = 0; k < N; k++) begin : g_lane
    sad_accum_lane #(
      .N   (N),
      .B   (B),
      .LANE(k)
    ) u_lane (
      .clk       (clk_adc),
      .reset     (reset),
      .clear     (lane_clear),
      .sample_vld(sample_vld_q),
      .sample    (sample_q),
      .ref_sample(ref_mem[lane_phase[k]]),
      .ref_enable(ref_en_mem[lane_phase[k]]),
      .phase     (lane_phase[k]),
      .sum       (lane_sum[k]),
      .done      (lane_done[k])
    );
  end

  // At most one lane completes per sample, so an OR-mux picks its sum
  always_comb begin
    done_sum = '0;
    for (int k = 0; k < N; k++) begin
      if (lane_done[k]) done_sum = done_sum | lane_sum[k];
    end
  end

  // A window is real only once N samples have arrived since arming; lanes that close
  // early hold partial sums and are tagged not-full here
  always_comb begin
    window_full = armed_and_ready &&
                  (((state_q == StFill) && (fill_cnt_q == PW'(N - 2))) ||
                   (state_q == StRun) || (state_q == StHold) || (state_q == StDone));
  end

  // Full-window tag travels alongside the sample through the pipeline
  always_ff @(posedge clk_adc) begin
    if (reset || !armed_and_ready) begin
      full_q <= '0;
    end else begin
      full_q <= {full_q[SAD_LATENCY-2:0], window_full};
    end
  end

  // Next-state, compare and trigger qualification
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    triggered_d = triggered_q;
    count_d     = count_q;
    result_ok   = full_q[SAD_LATENCY-1] && (|lane_done);
    hit         = armed_and_ready && result_ok && (state_q == StRun) &&
                  (32'(done_sum) < threshold);

    if (!armed_and_ready) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          state_d     = StFill;
          fill_cnt_d  = '0;
          triggered_d = 1'b0;
          count_d     = '0;
        end
        StFill: begin
          if (fill_cnt_q == PW'(N - 2)) state_d = StRun;
          else fill_cnt_d = fill_cnt_q + 1'b1;
        end
        StRun: begin
          if (hit) begin
            if (!multiple_triggers) begin
              state_d = StDone;
            end else if (holdoff != '0) begin
              state_d    = StHold;
              hold_cnt_d = holdoff;
            end
          end
        end
        StHold: begin
          if (hold_cnt_q <= pHOLDOFF_WIDTH'(1)) state_d = StRun;
          else hold_cnt_d = hold_cnt_q - 1'b1;
        end
        StDone: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end

    if (hit) begin
      triggered_d = 1'b1;
      if (count_q != '1) count_d = count_q + 1'b1;
    end
  end

  // State, counters and the registered trigger pulse
  always_ff @(posedge clk_adc) begin
    if (reset) begin
      state_q     <= StIdle;
      fill_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      trigger_q   <= 1'b0;
      triggered_q <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      trigger_q   <= hit;
      triggered_q <= triggered_d;
      count_q     <= count_d;
    end
  end

  assign trigger      = trigger_q;
  assign triggered    = triggered_q;
  assign num_triggers = count_q;

`ifdef SAD_MIN_TRACK_EN
  logic [SW-1:0] sad_min_q;

  // Minimum over every full window since arm, suppressed results included
  always_ff @(posedge clk_adc) begin
    if (reset || (armed_and_ready && (state_q == StIdle))) begin
      sad_min_q <= '1;
    end else if (armed_and_ready && result_ok && (done_sum < sad_min_q)) begin
      sad_min_q <= done_sum;
    end
  end

  assign sad_min = sad_min_q;
`endif

endmodule

// File: tb/tb_sad_window_trigger.sv
// Randomized bench for sad_window_trigger against a window-level reference model.
module tb_sad_window_trigger;

  localparam int N  = 32;
  localparam int B  = 12;
  localparam int HW = 16;
  localparam int CW = 8;
  localparam int SW = $clog2(N) + B;

  logic          clk_adc = 1'b0;
  logic          reset = 1'b1;
  logic [B-1:0]  adc_datain = '0;
  logic          armed_and_ready = 1'b0;
  logic          ref_wr = 1'b0;
  logic [4:0]    ref_addr = '0;
  logic [B-1:0]  ref_data = '0;
  logic          ref_en = 1'b0;
  logic [31:0]   threshold = '0;
  logic          multiple_triggers = 1'b0;
  logic [HW-1:0] holdoff = '0;
  logic          trigger, triggered;
  logic [CW-1:0] num_triggers;
`ifdef SAD_MIN_TRACK_EN
  logic [SW-1:0] sad_min;
`endif

  sad_window_trigger #(
    .pREF_SAMPLES    (N),
    .pBITS_PER_SAMPLE(B),
    .pHOLDOFF_WIDTH  (HW),
    .pCOUNT_WIDTH    (CW)
  ) dut (
    .clk_adc          (clk_adc),
    .reset            (reset),
    .adc_datain       (adc_datain),
    .armed_and_ready  (armed_and_ready),
    .ref_wr           (ref_wr),
    .ref_addr         (ref_addr),
    .ref_data         (ref_data),
    .ref_en           (ref_en),
    .threshold        (threshold),
    .multiple_triggers(multiple_triggers),
    .holdoff          (holdoff),
    .trigger          (trigger),
    .triggered        (triggered),
`ifdef SAD_MIN_TRACK_EN
    .sad_min          (sad_min),
`endif
    .num_triggers     (num_triggers)
  );

  always #5 clk_adc = ~clk_adc;

  int checks = 0;
  int failures = 0;

  // Reference model: reference contents, sample history of the current arm session,
  // and window results waiting for their compare edge
  typedef struct {longint due; int sad;} res_t;
  int     m_ref[N];
  bit     m_en[N];
  int     hist[$];
  res_t   pend[$];
  bit     in_session = 0, fired = 0;
  logic   m_trig = 0, m_triggered = 0;
  int     m_count = 0;
  longint last_trig = -1000000, cyc = 0;
  int     want[N];

  function automatic int noise();
    return int'($urandom_range(4095, 0));
  endfunction

  function automatic void model_edge(input int x);
    res_t r;
    int s;
    bit allowed;
    if (reset) begin
      in_session = 0; hist.delete(); pend.delete();
      m_trig = 0; m_triggered = 0; m_count = 0; fired = 0;
      return;
    end
    if (!armed_and_ready) begin
      in_session = 0; pend.delete(); m_trig = 0;
      if (ref_wr) begin
        m_ref[ref_addr] = int'(ref_data);
        m_en[ref_addr]  = ref_en;
      end
      return;
    end
    if (!in_session) begin
      in_session = 1; hist.delete(); pend.delete();
      m_triggered = 0; m_count = 0; fired = 0; last_trig = -1000000;
    end
    m_trig = 0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (longint'(r.sad) < longint'(threshold)) begin
        allowed = multiple_triggers ? ((cyc - last_trig) > longint'(holdoff)) : !fired;
        if (allowed) begin
          m_trig = 1; fired = 1; last_trig = cyc; m_triggered = 1;
          if (m_count < (1 << CW) - 1) m_count++;
        end
      end
    end
    hist.push_back(x);
    if (hist.size() > N) void'(hist.pop_front());
    if (hist.size() == N) begin
      s = 0;
      for (int j = 0; j < N; j++) begin
        if (m_en[j]) s += (hist[j] > m_ref[j]) ? hist[j] - m_ref[j] : m_ref[j] - hist[j];
      end
      pend.push_back('{cyc + 3, s});
    end
  endfunction

  task automatic tick(input int x);
    adc_datain = x[B-1:0];
    @(posedge clk_adc);
    cyc++;
    model_edge(x);
    #1;
  endtask

  task automatic wr_ref(input int j, input int d, input logic e);
    ref_wr = 1'b1; ref_addr = j[4:0]; ref_data = d[B-1:0]; ref_en = e;
    tick(noise());
    ref_wr = 1'b0;
  endtask

  task automatic disarm();
    armed_and_ready = 1'b0;
    tick(noise());
  endtask

  // Drives a sample list; reports pulses and cycles where outputs disagree with the model
  task automatic play(input int stim[$], output int pulses, output int diffs,
                      output longint first_hit);
    pulses = 0; diffs = 0; first_hit = -1;
    foreach (stim[i]) begin
      tick(stim[i]);
      if (trigger === 1'b1) begin
        pulses++;
        if (first_hit < 0) first_hit = cyc;
      end
      if (trigger !== m_trig || triggered !== m_triggered ||
          num_triggers !== m_count[CW-1:0]) diffs++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(noise()); tick(noise());
    checks++;
    if (trigger !== 1'b0 || triggered !== 1'b0 || num_triggers !== '0) begin
      failures++;
      $display("FAIL reset_state got trig=%b trd=%b num=%0d want 0/0/0",
               trigger, triggered, num_triggers);
    end
    reset = 1'b0;
    for (int j = 0; j < N; j++) begin
      want[j] = noise();
      wr_ref(j, want[j], 1'b1);
    end
  endtask

  task automatic test_exact_match();
    int stim[$]; int p, d; longint fh, c0;
    threshold = 1; multiple_triggers = 0; disarm();
    armed_and_ready = 1'b1;
    repeat (10) stim.push_back(noise());
    for (int j = 0; j < N; j++) stim.push_back(want[j]);
    repeat (8) stim.push_back(noise());
    c0 = cyc;
    play(stim, p, d, fh);
    checks++;
    if (d != 0) begin failures++; $display("FAIL exact_model diffs=%0d want 0", d); end
    checks++;
    if (p != 1 || fh != c0 + 10 + N + 3) begin
      failures++;
      $display("FAIL exact_latency pulses=%0d at=%0d want 1 at %0d", p, fh, c0 + 10 + N + 3);
    end
    checks++;
    if (num_triggers !== 8'd1 || triggered !== 1'b1) begin
      failures++;
      $display("FAIL exact_flags num=%0d trd=%b want 1/1", num_triggers, triggered);
    end
  endtask

  task automatic test_threshold_boundary();
    int stim[$]; int pat[N]; int p, d; longint fh;
    multiple_triggers = 0;
    pat = want;
    pat[5] = (want[5] < 2048) ? want[5] + 100 : want[5] - 100;
    for (int pass = 0; pass < 2; pass++) begin
      stim.delete();
      threshold = (pass == 0) ? 100 : 101;
      disarm();
      armed_and_ready = 1'b1;
      repeat (10) stim.push_back(noise());
      for (int j = 0; j < N; j++) stim.push_back(pat[j]);
      repeat (8) stim.push_back(noise());
      play(stim, p, d, fh);
      checks++;
      if (d != 0 || p != pass) begin
        failures++;
        $display("FAIL threshold_%0d pulses=%0d diffs=%0d want %0d/0", threshold, p, d, pass);
      end
    end
  endtask

  task automatic test_masking();
    int stim[$]; int p, d; longint fh;
    disarm();
    wr_ref(3, want[3], 1'b0);
    wr_ref(17, want[17], 1'b0);
    threshold = 1; multiple_triggers = 0;
    armed_and_ready = 1'b1;
    repeat (6) stim.push_back(noise());
    for (int j = 0; j < N; j++) stim.push_back((j == 3 || j == 17) ? noise() : want[j]);
    repeat (8) stim.push_back(noise());
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 1) begin
      failures++; $display("FAIL masking pulses=%0d diffs=%0d want 1/0", p, d);
    end
    disarm();
    wr_ref(3, want[3], 1'b1);
    wr_ref(17, want[17], 1'b1);
  endtask

  task automatic test_single_mode();
    int stim[$]; int p, d; longint fh;
    threshold = 1; multiple_triggers = 0; disarm();
    armed_and_ready = 1'b1;
    repeat (10) stim.push_back(noise());
    for (int j = 0; j < N; j++) stim.push_back(want[j]);
    repeat (200 - N) stim.push_back(noise());
    for (int j = 0; j < N; j++) stim.push_back(want[j]);
    repeat (8) stim.push_back(noise());
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 1 || num_triggers !== 8'd1) begin
      failures++;
      $display("FAIL single_mode pulses=%0d num=%0d diffs=%0d want 1/1/0", p, num_triggers, d);
    end
  endtask

  task automatic test_holdoff();
    int stim[$]; int p, d; longint fh;
    disarm();
    // Masking indices 0..11 shrinks the match to 20 samples so matches can be 20 apart
    for (int j = 0; j < 12; j++) wr_ref(j, want[j], 1'b0);
    threshold = 1; multiple_triggers = 1; holdoff = 50;
    armed_and_ready = 1'b1;
    repeat (40) stim.push_back(noise());
    for (int j = 12; j < N; j++) stim.push_back(want[j]);
    for (int j = 12; j < N; j++) stim.push_back(want[j]);
    repeat (60) stim.push_back(noise());
    for (int j = 12; j < N; j++) stim.push_back(want[j]);
    repeat (8) stim.push_back(noise());
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 2 || num_triggers !== 8'd2) begin
      failures++;
      $display("FAIL holdoff pulses=%0d num=%0d diffs=%0d want 2/2/0", p, num_triggers, d);
    end
    disarm();
    for (int j = 0; j < 12; j++) wr_ref(j, want[j], 1'b1);
  endtask

  task automatic test_zero_threshold_and_saturation();
    int stim[$]; int p, d; longint fh;
    disarm();
    for (int j = 0; j < N; j++) wr_ref(j, 12'h5a5, 1'b1);
    threshold = 0; multiple_triggers = 1; holdoff = 0;
    armed_and_ready = 1'b1;
    repeat (80) stim.push_back(12'h5a5);
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 0) begin
      failures++; $display("FAIL zero_threshold pulses=%0d diffs=%0d want 0/0", p, d);
    end
    threshold = 1;
    stim.delete();
    repeat (300) stim.push_back(12'h5a5);
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 300 || num_triggers !== 8'd255 || triggered !== 1'b1) begin
      failures++;
      $display("FAIL saturation pulses=%0d num=%0d diffs=%0d want 300/255/0",
               p, num_triggers, d);
    end
    disarm();
    armed_and_ready = 1'b1;
    tick(12'h5a5);
    checks++;
    if (num_triggers !== '0 || triggered !== 1'b0 || trigger !== 1'b0) begin
      failures++;
      $display("FAIL rearm_clear num=%0d trd=%b trig=%b want 0/0/0",
               num_triggers, triggered, trigger);
    end
    disarm();
    for (int j = 0; j < N; j++) wr_ref(j, want[j], 1'b1);
  endtask

  task automatic test_ref_wr_armed();
    int stim[$]; int p, d; longint fh;
    threshold = 1; multiple_triggers = 0; disarm();
    armed_and_ready = 1'b1;
    for (int j = 0; j < 8; j++) wr_ref(j * 4, want[j * 4] ^ 12'hfff, 1'b1);
    repeat (5) stim.push_back(noise());
    for (int j = 0; j < N; j++) stim.push_back(want[j]);
    repeat (8) stim.push_back(noise());
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 1) begin
      failures++; $display("FAIL ref_wr_armed pulses=%0d diffs=%0d want 1/0", p, d);
    end
  endtask

  task automatic test_reset_mid_window();
    int stim[$]; int p, d; longint fh;
    threshold = 1; multiple_triggers = 1; holdoff = 0; disarm();
    armed_and_ready = 1'b1;
    repeat (5) stim.push_back(noise());
    for (int j = 0; j < N; j++) stim.push_back(want[j]);
    repeat (3) stim.push_back(noise());
    for (int j = 0; j < 20; j++) stim.push_back(want[j]);
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 1) begin
      failures++; $display("FAIL pre_reset pulses=%0d diffs=%0d want 1/0", p, d);
    end
    reset = 1'b1;
    tick(noise());
    checks++;
    if (trigger !== 1'b0 || triggered !== 1'b0 || num_triggers !== '0) begin
      failures++;
      $display("FAIL mid_reset trig=%b trd=%b num=%0d want 0/0/0",
               trigger, triggered, num_triggers);
    end
    reset = 1'b0;
    stim.delete();
    for (int j = 20; j < N; j++) stim.push_back(want[j]);
    repeat (N) stim.push_back(noise());
    play(stim, p, d, fh);
    checks++;
    if (d != 0 || p != 0) begin
      failures++; $display("FAIL post_reset pulses=%0d diffs=%0d want 0/0", p, d);
    end
  endtask

  initial begin
    test_reset();
    test_exact_match();
    test_threshold_boundary();
    test_masking();
    test_single_mode();
    test_holdoff();
    test_zero_threshold_and_saturation();
    test_ref_wr_armed();
    test_reset_mid_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
